// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display controller:
// register map, CTRL bit positions, segment ordering and hex font.
package sseg_pkg;

   localparam int BUS_AW = 3;
   localparam int BUS_DW = 32;

   localparam logic [BUS_AW-1:0] REG_DATA  = 3'd0;
   localparam logic [BUS_AW-1:0] REG_BLANK = 3'd1;
   localparam logic [BUS_AW-1:0] REG_BLINK = 3'd2;
   localparam logic [BUS_AW-1:0] REG_CTRL  = 3'd3;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_PHASE   = 1;
   localparam int CTRL_RESTART = 2;

   // Segment a is bit 0, segment g is bit 6.
   localparam int SEG_A = 0;
   localparam int SEG_G = 6;
   localparam int SEG_W = SEG_G - SEG_A + 1;

   // Active-high font, entry 15 first.
   localparam logic [15:0][SEG_W-1:0] SEG_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] n);
      return SEG_FONT[n];
   endfunction

endpackage

// File: rtl/sseg_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the display controller.
// address/chipselect/write_n/writedata from master, readdata back.
interface sseg_display_ctrl_if;
   import sseg_pkg::*;

   logic [BUS_AW-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_DW-1:0] writedata;
   logic [BUS_DW-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble to seven-segment decoder.
// nibble in, seg out (bit 0 = a); ACTIVE_LOW inverts the font.
module sseg_hex_decoder
   import sseg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);

   assign seg = ACTIVE_LOW ? ~hex_font(nibble)
                           : hex_font(nibble);

endmodule

// File: rtl/sseg_display_ctrl.sv
// Memory-mapped seven-segment controller with blank/blink/enable.
// Ports: clk, reset (async high), bus (Avalon slave), out_port.
module sseg_display_ctrl
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BLINK_DIV      = 25000000
) (
   input  logic                        clk,
   input  logic                        reset,
   sseg_display_ctrl_if.slave          bus,
   output logic [SEG_W*NUM_DIGITS-1:0] out_port
);

   localparam int CW = $clog2(BLINK_DIV);
   localparam int DW = 4 * NUM_DIGITS;
   localparam bit ALOW = (SEG_ACTIVE_LOW != 0);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
   localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ALOW}};

   logic [DW-1:0]         data_q;
   logic [NUM_DIGITS-1:0] blank_q;
   logic [NUM_DIGITS-1:0] blink_q;
   logic                  enable_q;
   logic                  phase_q;
   logic [CW-1:0]         cnt_q;
   logic [SEG_W*NUM_DIGITS-1:0] seg_q;
   logic [SEG_W*NUM_DIGITS-1:0] seg_d;

   logic wr;
   logic wr_data;
   logic wr_blank;
   logic wr_blink;
   logic wr_ctrl;
   logic restart;
   logic terminal;
   logic [BUS_DW-1:0] rd;
   logic unused_wd;

   assign wr       = bus.chipselect & ~bus.write_n;
   assign wr_data  = wr & (bus.address == REG_DATA);
   assign wr_blank = wr & (bus.address == REG_BLANK);
   assign wr_blink = wr & (bus.address == REG_BLINK);
   assign wr_ctrl  = wr & (bus.address == REG_CTRL);
   assign restart  = wr_ctrl & bus.writedata[CTRL_RESTART];
   assign terminal = (cnt_q == CNT_LAST);
   assign unused_wd = ^bus.writedata;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic [SEG_W-1:0] dec;
      logic             off;

      sseg_hex_decoder #(
         .ACTIVE_LOW(ALOW)
      ) u_dec (
         .nibble(data_q[4*i +: 4]),
         .seg   (dec)
      );

      assign off = ~enable_q | blank_q[i]
                 | (blink_q[i] & phase_q);
      assign seg_d[SEG_W*i +: SEG_W] = off ? SEG_OFF : dec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q   <= '0;
         blank_q  <= '0;
         blink_q  <= '0;
         enable_q <= 1'b1;
         phase_q  <= 1'b0;
         cnt_q    <= '0;
         seg_q    <= {NUM_DIGITS{SEG_OFF}};
      end else begin
         if (wr_data)  data_q  <= bus.writedata[DW-1:0];
         if (wr_blank) blank_q <= bus.writedata[NUM_DIGITS-1:0];
         if (wr_blink) blink_q <= bus.writedata[NUM_DIGITS-1:0];
         if (wr_ctrl)  enable_q <= bus.writedata[CTRL_ENABLE];
         // Restart has priority over the terminal-count toggle.
         if (restart) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
         end else if (terminal) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q   <= cnt_q + 1'b1;
         end
         seg_q <= seg_d;
      end
   end

   always_comb begin
      rd = '0;
      case (bus.address)
         REG_DATA:  rd[DW-1:0] = data_q;
         REG_BLANK: rd[NUM_DIGITS-1:0] = blank_q;
         REG_BLINK: rd[NUM_DIGITS-1:0] = blink_q;
         REG_CTRL: begin
            rd[CTRL_ENABLE] = enable_q;
            rd[CTRL_PHASE]  = phase_q;
         end
         default: rd = '0;
      endcase
   end

   assign bus.readdata = rd;
   assign out_port     = seg_q;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Self-checking bench for sseg_display_ctrl (2 digits, active-low,
// blink divider 4) against a behavioural model.
module tb_sseg_display_ctrl;

   localparam int ND = 2;
   localparam int BD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] out_port;

   always #5 clk = ~clk;

   sseg_display_ctrl_if bus ();

   sseg_display_ctrl #(
      .NUM_DIGITS(ND),
      .SEG_ACTIVE_LOW(1),
      .BLINK_DIV(BD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .out_port(out_port)
   );

   int compared = 0;
   int mismatched = 0;

   // Model state: registers, and edges elapsed since reset/restart.
   int m_data, m_blank, m_blink, m_en, k;
   logic [13:0] m_out;

   logic [6:0] font [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int phase();
      return (k / BD) % 2;
   endfunction

   function automatic logic [13:0] render();
      logic [13:0] r;
      int nib;
      bit off;
      r = '0;
      for (int i = 0; i < ND; i++) begin
         nib = (m_data >> (4 * i)) & 15;
         off = (m_en == 0) || (((m_blank >> i) & 1) == 1) ||
               ((((m_blink >> i) & 1) == 1) && (phase() == 1));
         r[7*i +: 7] = off ? 7'h7F : ~font[nib];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      case (a)
         0: return 32'(m_data);
         1: return 32'(m_blank);
         2: return 32'(m_blink);
         3: return 32'(m_en | (phase() << 1));
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_data = 0; m_blank = 0; m_blink = 0; m_en = 1; k = 0;
      m_out = 14'h3FFF;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit cs, input bit wn, input int a,
                       input logic [31:0] wd);
      bit restart;
      bus.chipselect = cs;
      bus.write_n = wn;
      bus.address = 3'(a);
      bus.writedata = wd;
      @(posedge clk);
      m_out = render();
      restart = 0;
      if (cs && !wn) begin
         case (a)
            0: m_data = int'(wd & 32'hFF);
            1: m_blank = int'(wd & 32'h3);
            2: m_blink = int'(wd & 32'h3);
            3: begin m_en = int'(wd[0]); restart = wd[2]; end
            default: ;
         endcase
      end
      if (restart) k = 0;
      else k++;
      #1;
      chk("out_port", 32'(out_port), 32'(m_out));
      chk("readdata", bus.readdata, model_read(a));
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
   endtask

   task automatic idle(input int a);
      step(1'b0, 1'b1, a, 32'h0);
   endtask

   task automatic rd(input int a);
      bus.address = 3'(a);
      #1;
      chk("reg_read", bus.readdata, model_read(a));
   endtask

   initial begin
      bit found;
      logic [31:0] wd;
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      bus.address = '0;
      bus.writedata = '0;
      model_reset();
      #12;
      reset = 1'b0;
      step(1'b1, 1'b0, 0, 32'h37);
      idle(0);
      idle(0);

      // Reset mid-stream.
      reset = 1'b1;
      #1;
      model_reset();
      chk("reset_out", 32'(out_port), 32'h3FFF);
      #2;
      reset = 1'b0;
      for (int a = 0; a < 4; a++) rd(a);
      chk("reset_ctrl", bus.readdata, 32'h1);
      idle(0);
      chk("release_out", 32'(out_port), 32'h2040);

      // Decode.
      step(1'b1, 1'b0, 0, 32'h5A);
      chk("data_rb", bus.readdata, 32'h5A);
      idle(0);
      chk("decode_5A", 32'(out_port), 32'h0908);
      step(1'b1, 1'b0, 0, 32'hFFFF_FFFF);
      chk("data_mask", bus.readdata, 32'hFF);
      step(1'b1, 1'b0, 0, 32'h5A);
      idle(0);

      // Blank and enable.
      step(1'b1, 1'b0, 1, 32'h2);
      idle(1);
      chk("blank_d1", 32'(out_port[13:7]), 32'h7F);
      chk("blank_d0", 32'(out_port[6:0]), 32'h08);
      step(1'b1, 1'b0, 3, 32'h0);
      idle(3);
      chk("disable", 32'(out_port), 32'h3FFF);
      step(1'b1, 1'b0, 3, 32'h1);
      step(1'b1, 1'b0, 1, 32'h0);
      idle(3);
      chk("restore", 32'(out_port), 32'h0908);

      // Blink on digit 0; digit 1 must stay steady.
      step(1'b1, 1'b0, 2, 32'h1);
      for (int i = 0; i < 20; i++) begin
         idle(3);
         chk("steady_d1", 32'(out_port[13:7]), 32'h12);
      end

      // Restart landing on the terminal count while PHASE=0.
      found = 0;
      for (int i = 0; i < 16 && !found; i++) begin
         if ((k % BD) == BD - 1 && phase() == 0) found = 1;
         else idle(3);
      end
      chk("collision_found", 32'(found), 32'h1);
      step(1'b1, 1'b0, 3, 32'h5);
      chk("restart_ph0", bus.readdata, 32'h1);
      for (int i = 0; i < 3; i++) begin
         idle(3);
         chk("restart_hold", bus.readdata, 32'h1);
      end
      idle(3);
      chk("restart_ph1", bus.readdata, 32'h3);

      // Unused address and unselected write.
      step(1'b1, 1'b0, 5, 32'hFFFF_FFFF);
      chk("addr5_rd", bus.readdata, 32'h0);
      for (int a = 0; a < 4; a++) rd(a);
      step(1'b0, 1'b0, 0, 32'h12);
      chk("nocs_data", bus.readdata, 32'h5A);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         wd = $urandom;
         if ($urandom_range(0, 7) != 0) wd[2] = 1'b0;
         if ($urandom_range(0, 3) == 0) wd[0] = 1'b1;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), wd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sseg_display_ctrl.md
# sseg_display_ctrl

Memory-mapped seven-segment display controller for up to eight hex digits. It is an Avalon-MM slave on the Nios II system bus, replacing the fixed-width per-display output PIOs. Software writes one 4-bit nibble per digit, and the block performs the hex-to-segment decode in hardware. It adds per-digit blanking, per-digit blinking from an internal prescaler, a global enable, and a registered segment output.

## Interface
- NUM_DIGITS, 2, number of digits driven; legal range 1..8.
- SEG_ACTIVE_LOW, 1, 1 means a lit segment is driven 0 (DE-series boards).
- BLINK_DIV, 25000000, clock cycles per blink half-period; legal range ≥2.

- clk  in  1  system clock; one clock domain only.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of the register to access.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- out_port  out  7*NUM_DIGITS  segment outputs; digit i occupies [7i+6:7i]; bit 0 = segment a … bit 6 = segment g.

## Operation
- Registers, all written when chipselect=1 and write_n=0:
  - 0 DATA: nibble i is at [4i+3:4i].
  - 1 BLANK: bit i=1 turns digit i off.
  - 2 BLINK: bit i=1 makes digit i blink.
  - 3 CTRL: bit0 ENABLE (R/W); bit1 PHASE (read-only); bit2 RESTART (write-1 strobe, reads 0).
- Register bits above the configured width are ignored on write and read 0. Addresses 4..7 ignore writes and read 0. Reads have no side effects.
- Decode font, active-high form (inverted when SEG_ACTIVE_LOW=1): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Digit i is off when any of these holds: ENABLE=0; BLANK[i]=1; BLINK[i]=1 and PHASE=1. Otherwise digit i shows the decoded DATA nibble.
- Off means all seven segments unlit, i.e. 7'h7F when active-low and 7'h00 when active-high.
- Blink prescaler counts 0..BLINK_DIV-1 and free-runs whether or not ENABLE is set.
  - At the terminal count it wraps to 0 and PHASE toggles.
  - A RESTART write forces count=0 and PHASE=0 on that edge. RESTART wins over a coincident terminal count.

## Timing
- Reset values: DATA=0, BLANK=0, BLINK=0, ENABLE=1, PHASE=0, count=0.
- During reset, out_port is all digits off (all ones when active-low).
- The first edge after reset release loads "0" on every digit.
- Register writes take effect on the clock edge that samples the write. out_port reflects the write one cycle later (registered output stage).
- readdata returns the new value in the cycle after the write edge.
- A PHASE toggle at edge N appears on out_port at edge N+1.
- After RESTART, the first PHASE=1 occurs BLINK_DIV cycles after the RESTART edge.
- A write with chipselect=0 has no effect.

## Structure
- Package sseg_pkg holds:
  - register offset constants (DATA/BLANK/BLINK/CTRL);
  - CTRL bit positions;
  - the 16-entry font constant;
  - the segment ordering.
- Sub-module sseg_hex_decoder is a combinational nibble → 7-bit decoder with an active-low option, instantiated NUM_DIGITS times.
- The prescaler width is $clog2(BLINK_DIV).
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Configuration for all scenarios: NUM_DIGITS=2, SEG_ACTIVE_LOW=1, BLINK_DIV=4.
- Reset: assert reset mid-stream → out_port=14'h3FFF immediately. Release → out_port=14'h2040 ("00") one cycle later. Every register reads its reset value.
- Decode: write DATA=0x5A → out_port=14'h0908 one cycle after the write edge. DATA reads back 0x5A. Write DATA=0xFFFF_FFFF → DATA reads 0x000000FF.
- Blank and enable: BLANK=2'b10 → digit1=7'h7F while digit0 stays decoded. CTRL=0 → out_port=14'h3FFF. CTRL=1 → display restored one cycle later.
- Blink: BLINK=2'b01 → digit0 alternates 4 cycles on / 4 cycles off, and CTRL.PHASE readback tracks the alternation. digit1 stays steady throughout.
- Restart collision: write CTRL=3'b101 in the cycle where the prescaler is at its terminal count → PHASE=0 and count=0, with no toggle. The next PHASE=1 occurs exactly 4 cycles later.
- Unused and unselected accesses: write to address 5 → no register changes and readdata=0. Write DATA with chipselect=0 → DATA unchanged.
